// File: rtl/rs_issue_select.sv
// rs_issue_select: reservation-station storage and dispatch for one functional unit.
// The entries form an age-ordered compacting queue with slot 0 the oldest. Entries wake
// up by snooping the CDB. Each cycle the oldest entry with both operands ready is
// offered on a valid/ready issue port.
module rs_issue_select #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 8,
   parameter int TAG_W  = 3
) (
   input  logic                      clk2,
   input  logic                      rst_n,
   input  logic                      alloc_valid,
   output logic                      alloc_ready,
   input  logic [3:0]                alloc_func,
   input  logic [TAG_W-1:0]          alloc_rob,
   input  logic                      alloc_src1_rdy,
   input  logic                      alloc_src2_rdy,
   input  logic [DATA_W-1:0]         alloc_src1,
   input  logic [DATA_W-1:0]         alloc_src2,
   input  logic                      cdb_valid,
   input  logic [TAG_W-1:0]          cdb_rob,
   input  logic [DATA_W-1:0]         cdb_value,
   input  logic                      flush,
   output logic                      issue_valid,
   input  logic                      issue_ready,
   output logic [3:0]                issue_func,
   output logic [TAG_W-1:0]          issue_rob,
   output logic [DATA_W-1:0]         issue_op1,
   output logic [DATA_W-1:0]         issue_op2,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int IDX_W = $clog2(DEPTH);

   // Entry storage. A slot is valid exactly when its index is below count_q.
   logic [3:0]        func_q   [DEPTH];
   logic [TAG_W-1:0]  rob_q    [DEPTH];
   logic              s1_rdy_q [DEPTH];
   logic              s2_rdy_q [DEPTH];
   logic [DATA_W-1:0] s1_q     [DEPTH];
   logic [DATA_W-1:0] s2_q     [DEPTH];
   logic [3:0]        func_d   [DEPTH];
   logic [TAG_W-1:0]  rob_d    [DEPTH];
   logic              s1_rdy_d [DEPTH];
   logic              s2_rdy_d [DEPTH];
   logic [DATA_W-1:0] s1_d     [DEPTH];
   logic [DATA_W-1:0] s2_d     [DEPTH];
   logic [CNT_W-1:0]  count_q, count_d;

   // Source fields after this cycle's CDB capture, before the shift.
   logic              cap_s1_rdy [DEPTH];
   logic              cap_s2_rdy [DEPTH];
   logic [DATA_W-1:0] cap_s1     [DEPTH];
   logic [DATA_W-1:0] cap_s2     [DEPTH];

   logic              any_elig;
   logic [IDX_W-1:0]  sel;
   logic              alloc_fire, issue_fire;
   logic [CNT_W-1:0]  wr_idx;
   logic              new_s1_rdy, new_s2_rdy;
   logic [DATA_W-1:0] new_s1, new_s2;

   assign alloc_ready = (count_q < CNT_W'(DEPTH));
   // An opcode with bit 3 set is accepted on the handshake but never written.
   assign alloc_fire  = alloc_valid && alloc_ready && !alloc_func[3];
   assign issue_valid = any_elig && !flush;
   assign issue_fire  = issue_valid && issue_ready;
   assign count       = count_q;
   // After a same-cycle issue the younger entries have moved down, so the new entry lands one slot lower.
   assign wr_idx      = count_q - CNT_W'(issue_fire);

   // The payload is forced to zero whenever no entry is offered.
   assign issue_func = issue_valid ? func_q[sel] : '0;
   assign issue_rob  = issue_valid ? rob_q[sel]  : '0;
   assign issue_op1  = issue_valid ? s1_q[sel]   : '0;
   assign issue_op2  = issue_valid ? s2_q[sel]   : '0;

   // Pick the lowest-index (oldest) valid slot whose operands are both ready.
   always_comb begin
      any_elig = 1'b0;
      sel      = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (CNT_W'(i) < count_q && s1_rdy_q[i] && s2_rdy_q[i]) begin
            any_elig = 1'b1;
            sel      = IDX_W'(i);
         end
      end
   end

   // Snoop the CDB. Every waiting source whose tag matches captures the broadcast value.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         cap_s1_rdy[i] = s1_rdy_q[i];
         cap_s1[i]     = s1_q[i];
         cap_s2_rdy[i] = s2_rdy_q[i];
         cap_s2[i]     = s2_q[i];
         if (cdb_valid && !s1_rdy_q[i] && s1_q[i][TAG_W-1:0] == cdb_rob) begin
            cap_s1_rdy[i] = 1'b1;
            cap_s1[i]     = cdb_value;
         end
         if (cdb_valid && !s2_rdy_q[i] && s2_q[i][TAG_W-1:0] == cdb_rob) begin
            cap_s2_rdy[i] = 1'b1;
            cap_s2[i]     = cdb_value;
         end
      end
   end

   // An incoming source that is still a tag can be satisfied by the same-cycle broadcast.
   always_comb begin
      new_s1_rdy = alloc_src1_rdy;
      new_s1     = alloc_src1;
      new_s2_rdy = alloc_src2_rdy;
      new_s2     = alloc_src2;
      if (!alloc_src1_rdy && cdb_valid && alloc_src1[TAG_W-1:0] == cdb_rob) begin
         new_s1_rdy = 1'b1;
         new_s1     = cdb_value;
      end
      if (!alloc_src2_rdy && cdb_valid && alloc_src2[TAG_W-1:0] == cdb_rob) begin
         new_s2_rdy = 1'b1;
         new_s2     = cdb_value;
      end
   end

   // Next state: remove the issued slot, shift the younger slots down with any capture kept, then append.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         if (issue_fire && IDX_W'(i) >= sel && i < DEPTH - 1) begin
            func_d[i]   = func_q[i+1];
            rob_d[i]    = rob_q[i+1];
            s1_rdy_d[i] = cap_s1_rdy[i+1];
            s1_d[i]     = cap_s1[i+1];
            s2_rdy_d[i] = cap_s2_rdy[i+1];
            s2_d[i]     = cap_s2[i+1];
         end else begin
            func_d[i]   = func_q[i];
            rob_d[i]    = rob_q[i];
            s1_rdy_d[i] = cap_s1_rdy[i];
            s1_d[i]     = cap_s1[i];
            s2_rdy_d[i] = cap_s2_rdy[i];
            s2_d[i]     = cap_s2[i];
         end
         if (alloc_fire && CNT_W'(i) == wr_idx) begin
            func_d[i]   = alloc_func;
            rob_d[i]    = alloc_rob;
            s1_rdy_d[i] = new_s1_rdy;
            s1_d[i]     = new_s1;
            s2_rdy_d[i] = new_s2_rdy;
            s2_d[i]     = new_s2;
         end
      end
      // Flush overrides everything. Emptying the queue is enough, because slot contents beyond count are ignored.
      if (flush) count_d = '0;
      else       count_d = count_q - CNT_W'(issue_fire) + CNT_W'(alloc_fire);
   end

   // Occupancy register, the only state that needs a reset.
   always_ff @(posedge clk2 or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   // Entry payload storage.
   always_ff @(posedge clk2) begin
      // NOTE: the entry array is deliberately not reset. count_q masks every slot, so stale data is never observed.
      for (int i = 0; i < DEPTH; i++) begin
         func_q[i]   <= func_d[i];
         rob_q[i]    <= rob_d[i];
         s1_rdy_q[i] <= s1_rdy_d[i];
         s1_q[i]     <= s1_d[i];
         s2_rdy_q[i] <= s2_rdy_d[i];
         s2_q[i]     <= s2_d[i];
      end
   end

endmodule

// File: tb/tb_rs_issue_select.sv
// Directed testbench for rs_issue_select (DEPTH=4, DATA_W=8, TAG_W=3).
module tb_rs_issue_select;

   logic       clk2 = 1'b0;
   logic       rst_n;
   logic       alloc_valid, alloc_ready;
   logic [3:0] alloc_func;
   logic [2:0] alloc_rob;
   logic       alloc_src1_rdy, alloc_src2_rdy;
   logic [7:0] alloc_src1, alloc_src2;
   logic       cdb_valid;
   logic [2:0] cdb_rob;
   logic [7:0] cdb_value;
   logic       flush;
   logic       issue_valid, issue_ready;
   logic [3:0] issue_func;
   logic [2:0] issue_rob;
   logic [7:0] issue_op1, issue_op2;
   logic [2:0] count;

   int n_checks = 0;
   int n_fail   = 0;

   rs_issue_select #(.DEPTH(4), .DATA_W(8), .TAG_W(3)) dut (
      .clk2(clk2), .rst_n(rst_n),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_func(alloc_func),
      .alloc_rob(alloc_rob), .alloc_src1_rdy(alloc_src1_rdy), .alloc_src2_rdy(alloc_src2_rdy),
      .alloc_src1(alloc_src1), .alloc_src2(alloc_src2),
      .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value), .flush(flush),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_func(issue_func),
      .issue_rob(issue_rob), .issue_op1(issue_op1), .issue_op2(issue_op2), .count(count)
   );

   always #5 clk2 = ~clk2;

   // Watchdog: the run must always end on its own.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Present one alloc for a single edge. Outputs are then sampled 1 time unit after that edge.
   task automatic alloc_one(input logic [3:0] f, input logic [2:0] rob,
                            input logic r1, input logic [7:0] s1,
                            input logic r2, input logic [7:0] s2);
      alloc_func = f; alloc_rob = rob;
      alloc_src1_rdy = r1; alloc_src1 = s1;
      alloc_src2_rdy = r2; alloc_src2 = s2;
      alloc_valid = 1'b1;
      @(posedge clk2); #1;
      alloc_valid = 1'b0;
   endtask

   task automatic step();
      @(posedge clk2); #1;
   endtask

   task automatic test_reset();
      // Reset asserted from time 0.
      #1;
      n_checks++; if (count !== 3'd0)      begin n_fail++; $display("FAIL por_count: got %0d want 0", count); end
      n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL por_alloc_ready: got %b want 1", alloc_ready); end
      n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL por_issue_valid: got %b want 0", issue_valid); end
      @(negedge clk2); rst_n = 1'b1;
      step();
      // Hold three entries whose src1 never wakes, then reset mid-run.
      issue_ready = 1'b0;
      alloc_one(4'd1, 3'd1, 1'b0, 8'h07, 1'b1, 8'h01);
      alloc_one(4'd2, 3'd2, 1'b0, 8'h07, 1'b1, 8'h02);
      alloc_one(4'd3, 3'd3, 1'b0, 8'h07, 1'b1, 8'h03);
      n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL held_count: got %0d want 3", count); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (count !== 3'd0)       begin n_fail++; $display("FAIL mid_rst_count: got %0d want 0", count); end
      n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_alloc_ready: got %b want 1", alloc_ready); end
      n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_issue_valid: got %b want 0", issue_valid); end
      n_checks++; if (issue_op1 !== 8'h00)  begin n_fail++; $display("FAIL mid_rst_op1: got %h want 00", issue_op1); end
      @(negedge clk2); rst_n = 1'b1;
      step();
      n_checks++; if (count !== 3'd0)       begin n_fail++; $display("FAIL post_rst_count: got %0d want 0", count); end
      n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_issue_valid: got %b want 0", issue_valid); end
   endtask

   task automatic test_simple_dispatch();
      issue_ready = 1'b1;
      alloc_one(4'b0000, 3'd2, 1'b1, 8'd5, 1'b1, 8'd9);
      n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL simple_valid: got %b want 1", issue_valid); end
      n_checks++; if (issue_func !== 4'd0)  begin n_fail++; $display("FAIL simple_func: got %h want 0", issue_func); end
      n_checks++; if (issue_rob !== 3'd2)   begin n_fail++; $display("FAIL simple_rob: got %0d want 2", issue_rob); end
      n_checks++; if (issue_op1 !== 8'd5)   begin n_fail++; $display("FAIL simple_op1: got %0d want 5", issue_op1); end
      n_checks++; if (issue_op2 !== 8'd9)   begin n_fail++; $display("FAIL simple_op2: got %0d want 9", issue_op2); end
      step();
      n_checks++; if (count !== 3'd0)       begin n_fail++; $display("FAIL simple_count_after: got %0d want 0", count); end
      n_checks++; if (issue_op2 !== 8'd0)   begin n_fail++; $display("FAIL simple_idle_op2: got %h want 00", issue_op2); end
   endtask

   task automatic test_wakeup_order();
      issue_ready = 1'b0;
      alloc_one(4'd1, 3'd1, 1'b0, 8'h04, 1'b1, 8'h07);   // A waits on tag 4
      alloc_one(4'd2, 3'd2, 1'b1, 8'h20, 1'b1, 8'h30);   // B ready
      n_checks++; if (issue_rob !== 3'd2)   begin n_fail++; $display("FAIL order_rob_b: got %0d want 2", issue_rob); end
      n_checks++; if (issue_op1 !== 8'h20)  begin n_fail++; $display("FAIL order_op1_b: got %h want 20", issue_op1); end
      issue_ready = 1'b1;
      step();
      n_checks++; if (count !== 3'd1)       begin n_fail++; $display("FAIL order_count: got %0d want 1", count); end
      n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL order_a_waits: got %b want 0", issue_valid); end
      cdb_valid = 1'b1; cdb_rob = 3'd4; cdb_value = 8'h3C;
      #1;
      n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL cdb_no_comb_path: got %b want 0", issue_valid); end
      step();
      cdb_valid = 1'b0;
      #1;
      n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL wake_valid: got %b want 1", issue_valid); end
      n_checks++; if (issue_rob !== 3'd1)   begin n_fail++; $display("FAIL wake_rob: got %0d want 1", issue_rob); end
      n_checks++; if (issue_op1 !== 8'h3C)  begin n_fail++; $display("FAIL wake_op1: got %h want 3c", issue_op1); end
      n_checks++; if (issue_op2 !== 8'h07)  begin n_fail++; $display("FAIL wake_op2: got %h want 07", issue_op2); end
      step();
      n_checks++; if (count !== 3'd0)       begin n_fail++; $display("FAIL wake_drained: got %0d want 0", count); end
   endtask

   task automatic test_alloc_bypass();
      issue_ready = 1'b0;
      cdb_valid = 1'b1; cdb_rob = 3'd6; cdb_value = 8'h11;
      alloc_one(4'd3, 3'd5, 1'b1, 8'h44, 1'b0, 8'h06);
      cdb_valid = 1'b0;
      #1;
      n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL bypass_valid: got %b want 1", issue_valid); end
      n_checks++; if (issue_op2 !== 8'h11)  begin n_fail++; $display("FAIL bypass_op2: got %h want 11", issue_op2); end
      n_checks++; if (issue_op1 !== 8'h44)  begin n_fail++; $display("FAIL bypass_op1: got %h want 44", issue_op1); end
      n_checks++; if (issue_func !== 4'd3)  begin n_fail++; $display("FAIL bypass_func: got %h want 3", issue_func); end
      issue_ready = 1'b1;
      step();
      n_checks++; if (count !== 3'd0)       begin n_fail++; $display("FAIL bypass_drained: got %0d want 0", count); end
   endtask

   task automatic test_full_simultaneous();
      logic [2:0] exp_rob [4];
      logic [7:0] exp_op1 [4];
      exp_rob = '{3'd1, 3'd2, 3'd3, 3'd6};
      exp_op1 = '{8'h11, 8'h12, 8'h13, 8'h66};
      issue_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         alloc_one(4'(4 + i), 3'(i), 1'b1, 8'(8'h10 + i), 1'b1, 8'h55);
      n_checks++; if (count !== 3'd4)       begin n_fail++; $display("FAIL full_count: got %0d want 4", count); end
      n_checks++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL full_alloc_ready: got %b want 0", alloc_ready); end
      // Issue slot 0 while an alloc is held. The alloc must not be taken this edge.
      alloc_func = 4'd2; alloc_rob = 3'd6; alloc_src1_rdy = 1'b1; alloc_src1 = 8'h66;
      alloc_src2_rdy = 1'b1; alloc_src2 = 8'h77; alloc_valid = 1'b1;
      issue_ready = 1'b1;
      step();
      issue_ready = 1'b0;
      #1;
      n_checks++; if (count !== 3'd3)       begin n_fail++; $display("FAIL simul_count: got %0d want 3", count); end
      n_checks++; if (issue_rob !== 3'd1)   begin n_fail++; $display("FAIL simul_head: got %0d want 1", issue_rob); end
      step();
      alloc_valid = 1'b0;
      n_checks++; if (count !== 3'd4)       begin n_fail++; $display("FAIL late_alloc_count: got %0d want 4", count); end
      // Back-to-back drain, one issue per cycle, in age order.
      issue_ready = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         n_checks++; if (issue_rob !== exp_rob[k]) begin n_fail++; $display("FAIL drain_rob[%0d]: got %0d want %0d", k, issue_rob, exp_rob[k]); end
         n_checks++; if (issue_op1 !== exp_op1[k]) begin n_fail++; $display("FAIL drain_op1[%0d]: got %h want %h", k, issue_op1, exp_op1[k]); end
         step();
      end
      n_checks++; if (count !== 3'd0)       begin n_fail++; $display("FAIL drain_count: got %0d want 0", count); end
   endtask

   task automatic test_flush_illegal();
      issue_ready = 1'b0;
      alloc_one(4'd1, 3'd1, 1'b1, 8'h01, 1'b1, 8'h02);
      alloc_one(4'd2, 3'd2, 1'b1, 8'h03, 1'b1, 8'h04);
      alloc_one(4'd3, 3'd3, 1'b1, 8'h05, 1'b1, 8'h06);
      issue_ready = 1'b1;
      flush = 1'b1;
      #1;
      n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_issue_valid: got %b want 0", issue_valid); end
      n_checks++; if (issue_op1 !== 8'h00)  begin n_fail++; $display("FAIL flush_op1: got %h want 00", issue_op1); end
      step();
      flush = 1'b0;
      issue_ready = 1'b0;
      #1;
      n_checks++; if (count !== 3'd0)       begin n_fail++; $display("FAIL flush_count: got %0d want 0", count); end
      alloc_one(4'b1000, 3'd4, 1'b1, 8'h09, 1'b1, 8'h0A);
      n_checks++; if (count !== 3'd0)       begin n_fail++; $display("FAIL illegal_empty_count: got %0d want 0", count); end
      alloc_one(4'd5, 3'd5, 1'b1, 8'h0B, 1'b1, 8'h0C);
      alloc_one(4'b1111, 3'd6, 1'b1, 8'h0D, 1'b1, 8'h0E);
      n_checks++; if (count !== 3'd1)       begin n_fail++; $display("FAIL illegal_count: got %0d want 1", count); end
      n_checks++; if (issue_rob !== 3'd5)   begin n_fail++; $display("FAIL illegal_head: got %0d want 5", issue_rob); end
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      alloc_valid = 1'b0; alloc_func = '0; alloc_rob = '0;
      alloc_src1_rdy = 1'b0; alloc_src2_rdy = 1'b0; alloc_src1 = '0; alloc_src2 = '0;
      cdb_valid = 1'b0; cdb_rob = '0; cdb_value = '0;
      flush = 1'b0; issue_ready = 1'b0;
      test_reset();
      test_simple_dispatch();
      test_wakeup_order();
      test_alloc_bypass();
      test_full_simultaneous();
      test_flush_illegal();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
